// File: rtl/baccarat_hand_bank.sv
// Baccarat card-hand store: N hands of M slots, one card appended per deal press.
// Cards come from a free-running 1..13 cycler or an external card bus.
module baccarat_hand_bank #(
  parameter int NUM_HANDS      = 2,
  parameter int CARDS_PER_HAND = 3,
  parameter int USE_EXT_CARD   = 0,
  localparam int HW = (NUM_HANDS > 2) ? $clog2(NUM_HANDS) : 1,
  localparam int CW = $clog2(CARDS_PER_HAND + 1)
) (
  input  logic                                  fast_clock,
  input  logic                                  reset,
  input  logic                                  deal_req,
  input  logic [HW-1:0]                         deal_hand,
  input  logic [3:0]                            ext_card,
  input  logic                                  clear,
  output logic                                  deal_ack,
  output logic                                  deal_err,
  output logic [3:0]                            card_out,
  output logic [NUM_HANDS*CARDS_PER_HAND*4-1:0] cards_flat,
  output logic [NUM_HANDS*CW-1:0]               count_flat,
  output logic [NUM_HANDS*4-1:0]                score_flat
);

  logic          sync1, sync2, sync3;
  logic          rise;
  logic [3:0]    gen;
  logic [3:0]    card;
  logic [3:0]    slots  [NUM_HANDS][CARDS_PER_HAND];
  logic [CW-1:0] counts [NUM_HANDS];
  logic [3:0]    scores [NUM_HANDS];
  logic [CW-1:0] sel_count;
  logic [3:0]    sel_score;
  logic          hand_ok;
  logic          full;
  logic          rank_ok;
  logic          accept;
  logic          reject;
  logic [3:0]    value;
  logic [4:0]    sum5;
  logic [3:0]    new_score;

  assign rise = sync2 & ~sync3;
  assign card = (USE_EXT_CARD != 0) ? ext_card : gen;

  always_ff @(posedge fast_clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      gen   <= 4'd1;
    end else begin
      sync1 <= deal_req;
      sync2 <= sync1;
      sync3 <= sync2;
      gen   <= (gen == 4'd13) ? 4'd1 : gen + 4'd1;
    end
  end

  // Out-of-range hand indices simply never match, leaving hand_ok low.
  always_comb begin
    sel_count = '0;
    sel_score = '0;
    hand_ok   = 1'b0;
    for (int h = 0; h < NUM_HANDS; h++) begin
      if (deal_hand == HW'(h)) begin
        sel_count = counts[h];
        sel_score = scores[h];
        hand_ok   = 1'b1;
      end
    end
  end

  always_comb begin
    full    = (sel_count == CW'(CARDS_PER_HAND));
    rank_ok = (USE_EXT_CARD == 0) || ((card != 4'd0) && (card <= 4'd13));
    accept  = rise & ~clear & hand_ok & ~full & rank_ok;
    reject  = rise & ~clear & ~accept;
    value   = (card <= 4'd9) ? card : 4'd0;
    sum5    = {1'b0, sel_score} + {1'b0, value};
    new_score = 4'((sum5 >= 5'd10) ? sum5 - 5'd10 : sum5);
  end

  always_ff @(posedge fast_clock or posedge reset) begin
    if (reset) begin
      deal_ack <= 1'b0;
      deal_err <= 1'b0;
      card_out <= 4'd0;
      for (int h = 0; h < NUM_HANDS; h++) begin
        counts[h] <= '0;
        scores[h] <= '0;
        for (int s = 0; s < CARDS_PER_HAND; s++) slots[h][s] <= 4'd0;
      end
    end else if (clear) begin
      deal_ack <= 1'b0;
      deal_err <= 1'b0;
      card_out <= 4'd0;
      for (int h = 0; h < NUM_HANDS; h++) begin
        counts[h] <= '0;
        scores[h] <= '0;
        for (int s = 0; s < CARDS_PER_HAND; s++) slots[h][s] <= 4'd0;
      end
    end else begin
      deal_ack <= accept;
      deal_err <= reject;
      if (accept) begin
        card_out <= card;
        for (int h = 0; h < NUM_HANDS; h++) begin
          if (deal_hand == HW'(h)) begin
            counts[h] <= counts[h] + CW'(1);
            scores[h] <= new_score;
            for (int s = 0; s < CARDS_PER_HAND; s++) begin
              if (sel_count == CW'(s)) slots[h][s] <= card;
            end
          end
        end
      end
    end
  end

  always_comb begin
    cards_flat = '0;
    count_flat = '0;
    score_flat = '0;
    for (int h = 0; h < NUM_HANDS; h++) begin
      count_flat[h*CW +: CW] = counts[h];
      score_flat[h*4 +: 4]   = scores[h];
      for (int s = 0; s < CARDS_PER_HAND; s++) begin
        cards_flat[(h*CARDS_PER_HAND+s)*4 +: 4] = slots[h][s];
      end
    end
  end

endmodule
